data_repack: RTL
================

DATA_REPACK -- requirements
Module: data_repack

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 32, output word width.
REQ-002 SHALL have parameter DATA_WIDTH, default 7, input value width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, output word FIFO entries (power of 2).
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-low reset.
REQ-006 SHALL have port valid_in, input, 1, data_in holds a value this cycle; there is no input backpressure.
REQ-007 SHALL have port data_in, input, DATA_WIDTH, the serialized value.
REQ-008 SHALL have port sop_in, input, 1, first value of a packet.
REQ-009 SHALL have port eop_in, input, 1, last value of a packet.
REQ-010 SHALL have port ready_in, input, 1, the downstream consumer can accept a word.
REQ-011 SHALL have port valid_out, input/output direction output, 1, data_out holds a word.
REQ-012 SHALL have port data_out, output, WORD_WIDTH, the packed word, LSB-first.
REQ-013 SHALL have port sop_out, output, 1, first word of a packet.
REQ-014 SHALL have port eop_out, output, 1, last word of a packet.
REQ-015 SHALL have port overflow, output, 1, one-cycle pulse when a word is dropped because the FIFO is full.
REQ-016 SHALL have port proto_err, output, 1, one-cycle pulse on sop_in inside an open packet.

Function
REQ-017 SHALL pack values LSB-first: each value goes into the accumulator at bit offset bit_cnt, and bit_cnt advances by DATA_WIDTH.
REQ-018 SHALL use an accumulator of WORD_WIDTH+DATA_WIDTH-1 bits and a 6-bit bit_cnt in the range 0..38.
REQ-019 SHALL, when bit_cnt after an add is at least WORD_WIDTH, push acc[31:0], shift the remainder down to bit 0, and reduce bit_cnt by WORD_WIDTH.
REQ-020 SHALL, on eop_in with a nonzero remainder, stage the zero-padded residual as a final word and push it the following cycle.
REQ-021 SHALL attach eop to the last pushed word of the packet: the residual word if one exists, otherwise the full word pushed on the eop value.
REQ-022 SHALL clear the accumulator, bit_cnt and the in_pkt flag after the final push.
REQ-023 SHALL accept a new sop value in the cycle immediately after eop, with no dead cycle; the residual push and the new packet's first value can coincide because that value cannot complete a word.
REQ-024 SHALL attach sop to the first word pushed after a sop_in.
REQ-025 SHALL, when sop_in and eop_in are both set on one value, emit a single word with the value in [6:0], sop=eop=1, and upper bits zero.
REQ-026 SHALL discard valid_in values with in_pkt=0 and sop_in=0.
REQ-027 SHALL, on sop_in while in_pkt=1, drop the partial accumulator, pulse proto_err, and start the new packet with this value.
REQ-028 SHALL use a FIFO with entries {sop, eop, word}; a word is transferred when valid_out&&ready_in.
REQ-029 SHALL raise valid_out the cycle after the first push into an empty FIFO (1-cycle latency).
REQ-030 SHALL sustain one word per cycle under simultaneous push and pop, including when the FIFO is full.
REQ-031 SHALL, on a push into a full FIFO with no pop, drop the word and pulse overflow; packing state continues.
REQ-032 SHALL hold data_out, sop_out and eop_out stable while valid_out&&!ready_in.

Reset
REQ-033 SHALL, when rst=0, clear the accumulator, bit_cnt, in_pkt, residual stage, FIFO pointers and count, valid_out, sop_out, eop_out, overflow, proto_err and data_out (to 0) by the next edge, including mid-packet.

Structure
REQ-034 SHALL place WORD_WIDTH and DATA_WIDTH defaults and the FIFO entry struct typedef {sop, eop, word} in the shared package.
REQ-035 SHALL implement the FIFO as one sub-module, word_fifo; the packing logic stays in data_repack.

Verification
REQ-036 SHALL cover: sop 7'h5A, then 7'h00, 7'h33, 7'h00, then 7'h7F with eop -> 32'hF00CC05A (sop) then 32'h00000007 (eop).
REQ-037 SHALL cover: single value 7'h55 with sop and eop -> one word 32'h00000055 with sop=eop=1.
REQ-038 SHALL cover: a 32-value packet (224 bits) -> exactly 7 words, eop on the 7th, no residual word, and the next packet's sop value accepted the following cycle.
REQ-039 SHALL cover: values before any sop, and values after eop, are discarded -> no words out.
REQ-040 SHALL cover: ready_in=0 while 5 words are produced -> 4 words held, overflow pulses once, first 4 words later drain in order.
REQ-041 SHALL cover: rst=0 after 3 values of a packet -> no output; the next packet packs from bit 0.

Source files
------------

// File: rtl/data_repack_pkg.sv
// Shared definitions for the data_repack packer and its output word FIFO.
package data_repack_pkg;

  // Default geometry: 7-bit values packed into 32-bit words, 4-entry FIFO.
  localparam int DEF_WORD_WIDTH = 32;
  localparam int DEF_DATA_WIDTH = 7;
  localparam int DEF_FIFO_DEPTH = 4;

  // One output FIFO entry. The word field follows DEF_WORD_WIDTH, so a
  // different word width is selected by changing the default here.
  typedef struct packed {
    logic                      sop;
    logic                      eop;
    logic [DEF_WORD_WIDTH-1:0] word;
  } fifo_entry_t;

endpackage

// File: rtl/data_repack_word_fifo.sv
// Small synchronous FIFO of packed output words with sop/eop framing.
// Simultaneous push and pop is accepted even when full; a push into a full
// FIFO without a pop is dropped and reported on overflow the next cycle.
module word_fifo
  import data_repack_pkg::*;
#(
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  fifo_entry_t entry,
  input  logic        ready,
  output logic        valid,
  output fifo_entry_t head,
  output logic        overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  fifo_entry_t      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             full;
  logic             pop;
  logic             write;

  assign full  = (count == FULL_COUNT);
  assign valid = (count != '0);
  assign pop   = valid && ready;
  // A full FIFO still takes a word when the head leaves in the same cycle.
  assign write = push && (!full || pop);

  // Unpopulated slots are never presented, so the head reads as zero when empty.
  assign head = valid ? mem[rd_ptr] : '0;

  // Storage write port.
  // NOTE: the storage array has no reset; only pointers and count need one,
  // and leaving it out keeps the array mappable to plain flops or RAM.
  always_ff @(posedge clk) begin
    if (write) begin
      mem[wr_ptr] <= entry;
    end
  end

  // Pointer, occupancy and overflow-pulse bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= push && full && !pop;
      if (write) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (write && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !write) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/data_repack.sv
// Packs a stream of narrow values LSB-first into wide words with packet
// framing, then buffers the words in a small FIFO toward a ready/valid sink.
module data_repack
  import data_repack_pkg::*;
#(
  parameter int WORD_WIDTH = DEF_WORD_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  sop_in,
  input  logic                  eop_in,
  input  logic                  ready_in,
  output logic                  valid_out,
  output logic [WORD_WIDTH-1:0] data_out,
  output logic                  sop_out,
  output logic                  eop_out,
  output logic                  overflow,
  output logic                  proto_err
);

  // Accumulator holds at most WORD_WIDTH-1 leftover bits plus one new value.
  localparam int ACC_W = WORD_WIDTH + DATA_WIDTH - 1;
  localparam int CNT_W = $clog2(ACC_W + 1);
  localparam logic [CNT_W-1:0] WORD_CNT = CNT_W'(WORD_WIDTH);
  localparam logic [CNT_W-1:0] DATA_CNT = CNT_W'(DATA_WIDTH);

  logic [ACC_W-1:0] acc,      acc_n;
  logic [CNT_W-1:0] bit_cnt,  bit_cnt_n;
  logic             in_pkt,   in_pkt_n;
  logic             sop_pend, sop_pend_n;
  logic             res_valid, res_valid_n;
  fifo_entry_t      res_entry, res_entry_n;
  logic             proto_err_n;

  logic [ACC_W-1:0] ext_data;
  logic [ACC_W-1:0] sum_acc;
  logic [CNT_W-1:0] sum_cnt;
  logic             word_push;
  fifo_entry_t      word_entry;
  logic             push;
  fifo_entry_t      push_entry;
  fifo_entry_t      head;

  assign ext_data = {{(ACC_W - DATA_WIDTH){1'b0}}, data_in};

  // Next-state packing: accept, accumulate, emit full words, stage residuals.
  // NOTE: every variable gets a default first so no path leaves one unassigned
  // (no latches), and blocking '=' is right here because later lines of this
  // combinational block read the values computed by earlier lines.
  always_comb begin
    acc_n       = acc;
    bit_cnt_n   = bit_cnt;
    in_pkt_n    = in_pkt;
    sop_pend_n  = sop_pend;
    res_valid_n = 1'b0;
    res_entry_n = res_entry;
    proto_err_n = 1'b0;
    sum_acc     = '0;
    sum_cnt     = '0;
    word_push   = 1'b0;
    word_entry  = '0;

    if (valid_in && (sop_in || in_pkt)) begin
      if (sop_in) begin
        // A sop inside an open packet abandons the partial accumulator.
        proto_err_n = in_pkt;
        sop_pend_n  = 1'b1;
        sum_acc     = ext_data;
        sum_cnt     = DATA_CNT;
      end else begin
        sum_acc = acc | (ext_data << bit_cnt);
        sum_cnt = bit_cnt + DATA_CNT;
      end

      if (sum_cnt >= WORD_CNT) begin
        word_push       = 1'b1;
        word_entry.word = sum_acc[WORD_WIDTH-1:0];
        word_entry.sop  = sop_pend_n;
        sop_pend_n      = 1'b0;
        sum_acc         = sum_acc >> WORD_WIDTH;
        sum_cnt         = sum_cnt - WORD_CNT;
        word_entry.eop  = eop_in && (sum_cnt == '0);
      end

      if (eop_in) begin
        // Leftover bits become a zero-padded final word pushed next cycle;
        // the packer is free immediately so a new sop needs no dead cycle.
        if (sum_cnt != '0) begin
          res_valid_n      = 1'b1;
          res_entry_n.sop  = sop_pend_n;
          res_entry_n.eop  = 1'b1;
          res_entry_n.word = sum_acc[WORD_WIDTH-1:0];
        end
        acc_n      = '0;
        bit_cnt_n  = '0;
        in_pkt_n   = 1'b0;
        sop_pend_n = 1'b0;
      end else begin
        acc_n     = sum_acc;
        bit_cnt_n = sum_cnt;
        in_pkt_n  = 1'b1;
      end
    end
  end

  // A staged residual never coincides with a full word: the value arriving
  // alongside it is at most the first of a new packet and cannot fill a word.
  assign push       = res_valid || word_push;
  assign push_entry = res_valid ? res_entry : word_entry;

  // Packing state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      acc       <= '0;
      bit_cnt   <= '0;
      in_pkt    <= 1'b0;
      sop_pend  <= 1'b0;
      res_valid <= 1'b0;
      res_entry <= '0;
      proto_err <= 1'b0;
    end else begin
      acc       <= acc_n;
      bit_cnt   <= bit_cnt_n;
      in_pkt    <= in_pkt_n;
      sop_pend  <= sop_pend_n;
      res_valid <= res_valid_n;
      res_entry <= res_entry_n;
      proto_err <= proto_err_n;
    end
  end

  word_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_word_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .entry    (push_entry),
    .ready    (ready_in),
    .valid    (valid_out),
    .head     (head),
    .overflow (overflow)
  );

  assign data_out = head.word;
  assign sop_out  = head.sop;
  assign eop_out  = head.eop;

endmodule
